// File: rtl/lzw_string_unwind.sv
// lzw_string_unwind
//   Takes one LZW code, follows the prefix-code / append-char dictionary back
//   to its root literal while pushing characters onto a LIFO, then pops the
//   LIFO so the string comes out in forward order.
//
// Ports
//   clk, rst_n                 clock, synchronous active-low reset
//   code_in/valid/ready        code to unwind (0-255 literal, 256-4095 entry)
//   dict_en/addr               dictionary read request (1-cycle latency)
//   dict_prefix/char           dictionary read data, sampled in WAIT only
//   char_out/valid/ready/last  output character stream
//   first_char                 root character of the last unwound string
//   busy                       walk or drain in progress
//   err                        one-cycle pulse on illegal code or overflow
module lzw_string_unwind #(
  parameter int STACK_AW = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [12:0] code_in,
  input  logic        code_valid,
  output logic        code_ready,
  output logic        dict_en,
  output logic [11:0] dict_addr,
  input  logic [12:0] dict_prefix,
  input  logic [7:0]  dict_char,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready,
  output logic        char_last,
  output logic [7:0]  first_char,
  output logic        busy,
  output logic        err
);

  localparam int DEPTH = 2 ** STACK_AW;
  localparam logic [STACK_AW:0] SP_FULL = {1'b1, {STACK_AW{1'b0}}};
  localparam logic [STACK_AW:0] SP_ONE  = (STACK_AW + 1)'(1);

  typedef enum logic [2:0] {S_IDLE, S_READ, S_WAIT, S_LIT, S_POP} state_t;

  state_t            state_q, state_d;
  logic [STACK_AW:0] sp_q, sp_d;
  logic [11:0]       cur_q, cur_d;
  logic [11:0]       dict_addr_q, dict_addr_d;
  logic [7:0]        first_q, first_d;
  logic              err_q, err_d;
  logic              push_en;
  logic [7:0]        push_data;
  logic [STACK_AW-1:0] top_idx;

  logic [7:0] stack_mem [DEPTH];

  // Stack storage carries no reset: a cleared stack pointer is enough to
  // discard whatever is left in it.
  always_ff @(posedge clk) begin
    if (push_en) begin
      stack_mem[sp_q[STACK_AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      sp_q        <= '0;
      cur_q       <= '0;
      dict_addr_q <= '0;
      first_q     <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sp_q        <= sp_d;
      cur_q       <= cur_d;
      dict_addr_q <= dict_addr_d;
      first_q     <= first_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    cur_d       = cur_q;
    dict_addr_d = dict_addr_q;
    first_d     = first_q;
    err_d       = 1'b0;
    push_en     = 1'b0;
    push_data   = '0;

    unique case (state_q)
      S_IDLE: begin
        if (code_valid && code_ready) begin
          if (code_in[12]) begin
            err_d = 1'b1;
          end else if (code_in[11:8] == 4'd0) begin
            push_en   = 1'b1;
            push_data = code_in[7:0];
            first_d   = code_in[7:0];
            state_d   = S_POP;
          end else begin
            cur_d   = code_in[11:0];
            state_d = S_READ;
          end
        end
      end
      S_READ: begin
        dict_addr_d = cur_q;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        if (dict_prefix[12]) begin
          // Corrupt dictionary link: abandon the whole string.
          err_d   = 1'b1;
          sp_d    = '0;
          state_d = S_IDLE;
        end else begin
          push_en   = 1'b1;
          push_data = dict_char;
          cur_d     = dict_prefix[11:0];
          state_d   = (dict_prefix[11:8] == 4'd0) ? S_LIT : S_READ;
        end
      end
      S_LIT: begin
        push_en   = 1'b1;
        push_data = cur_q[7:0];
        first_d   = cur_q[7:0];
        state_d   = S_POP;
      end
      S_POP: begin
        if (char_ready) begin
          sp_d = sp_q - SP_ONE;
          if (sp_q == SP_ONE) begin
            state_d = S_IDLE;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A push into a full stack aborts the string without emitting anything
    // and leaves first_char describing the previous good string.
    if (push_en) begin
      if (sp_q == SP_FULL) begin
        push_en = 1'b0;
        err_d   = 1'b1;
        sp_d    = '0;
        first_d = first_q;
        state_d = S_IDLE;
      end else begin
        sp_d = sp_q + SP_ONE;
      end
    end
  end

  assign top_idx    = sp_q[STACK_AW-1:0] - STACK_AW'(1);
  assign code_ready = rst_n && (state_q == S_IDLE);
  assign busy       = (state_q != S_IDLE);
  assign dict_en    = (state_q == S_READ);
  // Address is presented in the same cycle as dict_en, then held.
  assign dict_addr  = dict_en ? cur_q : dict_addr_q;
  assign char_valid = (state_q == S_POP);
  // Top of stack read asynchronously so the first character is visible in
  // the cycle right after the final push.
  assign char_out   = char_valid ? stack_mem[top_idx] : 8'h00;
  assign char_last  = char_valid && (sp_q == SP_ONE);
  assign first_char = first_q;
  assign err        = err_q;

endmodule

// File: tb/tb_lzw_string_unwind.sv
module tb_lzw_string_unwind;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [12:0] code_in;
  logic        code_valid;
  logic        char_ready;
  logic        sel_ov;

  // main instance (STACK_AW=12)
  logic        cr_a, den_a, cv_a, cl_a, busy_a, err_a;
  logic [11:0] da_a;
  logic [7:0]  co_a, fc_a, dc_a;
  logic [12:0] dp_a;
  // small-stack instance (STACK_AW=3) for overflow / exact-fill checks
  logic        cr_b, den_b, cv_b, cl_b, busy_b, err_b;
  logic [11:0] da_b;
  logic [7:0]  co_b, fc_b, dc_b;
  logic [12:0] dp_b;

  logic [12:0] dict_p [4096];
  logic [7:0]  dict_c [4096];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lzw_string_unwind #(.STACK_AW(12)) dut (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid && !sel_ov),
    .code_ready(cr_a), .dict_en(den_a), .dict_addr(da_a), .dict_prefix(dp_a),
    .dict_char(dc_a), .char_out(co_a), .char_valid(cv_a), .char_ready(char_ready),
    .char_last(cl_a), .first_char(fc_a), .busy(busy_a), .err(err_a));

  lzw_string_unwind #(.STACK_AW(3)) dut_ov (
    .clk(clk), .rst_n(rst_n), .code_in(code_in), .code_valid(code_valid && sel_ov),
    .code_ready(cr_b), .dict_en(den_b), .dict_addr(da_b), .dict_prefix(dp_b),
    .dict_char(dc_b), .char_out(co_b), .char_valid(cv_b), .char_ready(char_ready),
    .char_last(cl_b), .first_char(fc_b), .busy(busy_b), .err(err_b));

  // Dictionary RAM model with one cycle read latency, one port per instance.
  always @(posedge clk) begin
    if (den_a) begin dp_a <= dict_p[da_a]; dc_a <= dict_c[da_a]; end
    if (den_b) begin dp_b <= dict_p[da_b]; dc_b <= dict_c[da_b]; end
  end

  wire        m_cr   = sel_ov ? cr_b   : cr_a;
  wire        m_den  = sel_ov ? den_b  : den_a;
  wire [11:0] m_da   = sel_ov ? da_b   : da_a;
  wire        m_cv   = sel_ov ? cv_b   : cv_a;
  wire [7:0]  m_co   = sel_ov ? co_b   : co_a;
  wire        m_cl   = sel_ov ? cl_b   : cl_a;
  wire [7:0]  m_fc   = sel_ov ? fc_b   : fc_a;
  wire        m_busy = sel_ov ? busy_b : busy_a;
  wire        m_err  = sel_ov ? err_b  : err_a;

  typedef struct {
    logic        use_ov;
    logic [12:0] code;
    logic [7:0]  pat;       // char_ready per POP cycle, bit 0 first
    int          exp_len;
    logic [63:0] exp_str;   // first character in bits [7:0]
    logic        exp_err;
    int          exp_lat;   // cycles from accept to first char_valid (or err)
    logic [7:0]  exp_first;
  } vec_t;

  vec_t vecs [15];

  function automatic vec_t mk(input logic ov, input logic [12:0] c, input logic [7:0] p,
                              input int len, input logic [63:0] s, input logic e,
                              input int lat, input logic [7:0] f);
    vec_t v;
    v.use_ov = ov; v.code = c; v.pat = p; v.exp_len = len; v.exp_str = s;
    v.exp_err = e; v.exp_lat = lat; v.exp_first = f;
    return v;
  endfunction

  task automatic check(input logic ok, input string name, input logic [63:0] act,
                       input logic [63:0] req);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, req);
    end
  endtask

  // Called at a negedge with the selected instance idle.
  task automatic run_vec(input int idx, input vec_t v);
    logic [63:0] got = '0;
    int n = 0, first_cyc = -1, err_cnt = 0, err_cyc = -1, pi = 0, last_hs = 0, crlow = 0;
    logic saw_en = 1'b0, have_addr = 1'b0, prev_stall = 1'b0, rdy, prev_last = 1'b0;
    logic [11:0] first_addr = '0;
    logic [7:0]  prev_out = '0;
    int lat;
    sel_ov = v.use_ov;
    #1;
    check(m_cr == 1'b1, "ready_before", 64'(m_cr), 64'd1);
    code_in = v.code; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (m_err) begin err_cnt++; if (err_cyc < 0) err_cyc = c; end
      if (m_den) begin
        saw_en = 1'b1;
        if (!have_addr) begin first_addr = m_da; have_addr = 1'b1; end
      end
      if (last_hs > 0 && c == last_hs + 1)
        check(m_cr == 1'b1, "ready_after_last", 64'(m_cr), 64'd1);
      if (!m_cr) crlow++;
      if (m_cv) begin
        if (first_cyc < 0) first_cyc = c;
        if (prev_stall)
          check({m_co, m_cl} == {prev_out, prev_last}, "stall_hold",
                64'({m_co, m_cl}), 64'({prev_out, prev_last}));
        rdy = (pi < 8) ? v.pat[pi] : 1'b1;
        pi++;
        char_ready = rdy;
        prev_stall = !rdy; prev_out = m_co; prev_last = m_cl;
        if (rdy) begin
          if (n < 8) got[8*n +: 8] = m_co;
          check(m_cl == (n == v.exp_len - 1), "char_last", 64'(m_cl), 64'(n == v.exp_len - 1));
          n++;
          if (m_cl) last_hs = c;
        end
      end else begin
        char_ready = 1'b1;
        prev_stall = 1'b0;
      end
      @(negedge clk);
    end
    char_ready = 1'b1;
    lat = v.exp_err ? err_cyc : first_cyc;
    check(n == v.exp_len, "length", 64'(n), 64'(v.exp_len));
    check(got == v.exp_str, "string", got, v.exp_str);
    check(err_cnt == (v.exp_err ? 1 : 0), "err_pulses", 64'(err_cnt), 64'(v.exp_err));
    check(lat == v.exp_lat, "latency", 64'(lat), 64'(v.exp_lat));
    check(m_fc == v.exp_first, "first_char", 64'(m_fc), 64'(v.exp_first));
    check(m_busy == 1'b0 && m_cr == 1'b1, "idle_at_end", 64'({m_busy, m_cr}), 64'b01);
    if (v.code >= 13'd256 && v.code < 13'd4096)
      check(first_addr == v.code[11:0], "first_dict_addr", 64'(first_addr), 64'(v.code[11:0]));
    if (v.code >= 13'd4096) begin
      check(saw_en == 1'b0, "no_dict_en", 64'(saw_en), 64'd0);
      check(crlow == 0, "ready_stays_high", 64'(crlow), 64'd0);
    end
    $display("vec %0d inst %0d code %h chars %0d str %h err %0d lat %0d first %h",
             idx, v.use_ov, v.code, n, got, err_cnt, lat, m_fc);
  endtask

  initial begin
    int hs;
    rst_n = 1'b0; code_in = '0; code_valid = 1'b0; char_ready = 1'b1; sel_ov = 1'b0;
    for (int i = 0; i < 4096; i++) begin dict_p[i] = '0; dict_c[i] = '0; end
    dict_p[300] = 13'h061;  dict_c[300] = 8'h62;
    dict_p[301] = 13'd300;  dict_c[301] = 8'h63;
    dict_p[302] = 13'd301;  dict_c[302] = 8'h64;
    dict_p[303] = 13'h1FFF; dict_c[303] = 8'h55;
    dict_p[304] = 13'h041;  dict_c[304] = 8'h41;
    dict_p[256] = 13'h000;  dict_c[256] = 8'hFF;
    dict_p[4095] = 13'h0FF; dict_c[4095] = 8'h00;
    dict_p[400] = 13'h030;  dict_c[400] = 8'h31;
    for (int k = 1; k <= 8; k++) begin
      dict_p[400 + k] = 13'(400 + k - 1);
      dict_c[400 + k] = 8'(8'h31 + k);
    end

    vecs[0]  = mk(0, 13'h041, 8'hFF, 1, 64'h41, 0, 1, 8'h41);
    vecs[1]  = mk(0, 13'h000, 8'hFF, 1, 64'h00, 0, 1, 8'h00);
    vecs[2]  = mk(0, 13'h0FF, 8'hFF, 1, 64'hFF, 0, 1, 8'hFF);
    vecs[3]  = mk(0, 13'd300, 8'hFF, 2, 64'h6261, 0, 4, 8'h61);
    vecs[4]  = mk(0, 13'd301, 8'hFF, 3, 64'h636261, 0, 6, 8'h61);
    vecs[5]  = mk(0, 13'd302, 8'hFF, 4, 64'h64636261, 0, 8, 8'h61);
    vecs[6]  = mk(0, 13'd301, 8'hF9, 3, 64'h636261, 0, 6, 8'h61);
    vecs[7]  = mk(0, 13'd256, 8'hFF, 2, 64'hFF00, 0, 4, 8'h00);
    vecs[8]  = mk(0, 13'd4095, 8'hFF, 2, 64'h00FF, 0, 4, 8'hFF);
    vecs[9]  = mk(0, 13'h1000, 8'hFF, 0, 64'h0, 1, 1, 8'hFF);
    vecs[10] = mk(0, 13'h1FFF, 8'hFF, 0, 64'h0, 1, 1, 8'hFF);
    vecs[11] = mk(0, 13'd303, 8'hFF, 0, 64'h0, 1, 3, 8'hFF);
    vecs[12] = mk(0, 13'd304, 8'hFF, 2, 64'h4141, 0, 4, 8'h41);
    vecs[13] = mk(1, 13'd406, 8'hFF, 8, 64'h3736353433323130, 0, 16, 8'h30);
    vecs[14] = mk(1, 13'd408, 8'hFF, 0, 64'h0, 1, 19, 8'h30);

    // Reset values, sampled while rst_n is held low.
    repeat (3) @(negedge clk);
    check(cr_a == 1'b0, "rst_code_ready", 64'(cr_a), 64'd0);
    check({den_a, cv_a, cl_a, busy_a, err_a} == 5'b0, "rst_flags",
          64'({den_a, cv_a, cl_a, busy_a, err_a}), 64'd0);
    check({da_a, co_a, fc_a} == 28'd0, "rst_data", 64'({da_a, co_a, fc_a}), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check(cr_a == 1'b1, "code_ready_after_release", 64'(cr_a), 64'd1);

    for (int i = 0; i < 15; i++) run_vec(i, vecs[i]);

    // Reset while two characters of "abcd" remain in the stack.
    sel_ov = 1'b0;
    code_in = 13'd302; code_valid = 1'b1;
    @(negedge clk);
    code_valid = 1'b0;
    hs = 0;
    for (int c = 0; c < 30; c++) begin
      if (cv_a) begin
        if (hs == 2) break;
        hs++;
      end
      @(negedge clk);
    end
    check(hs == 2 && cv_a == 1'b1, "reach_mid_pop", 64'(hs), 64'd2);
    rst_n = 1'b0;
    @(negedge clk);
    check({cv_a, busy_a} == 2'b00, "mid_pop_rst_idle", 64'({cv_a, busy_a}), 64'd0);
    check(fc_a == 8'h00, "mid_pop_rst_first", 64'(fc_a), 64'd0);
    check(cr_a == 1'b0, "ready_gated_in_rst", 64'(cr_a), 64'd0);
    rst_n = 1'b1;
    run_vec(15, mk(0, 13'h07A, 8'hFF, 1, 64'h7A, 0, 1, 8'h7A));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lzw_string_unwind.md
# lzw_string_unwind

LZW decoder string unwinder: takes one code, walks the prefix-code and append-character dictionary back to its root literal, and emits the string's characters in forward order. The walk pushes characters onto an internal LIFO stack, then pops them out.
- Sits between the decoder's code input stage and the byte output stream.
- Is the read-side consumer of the dictionary that the encoder's prefix-code and append-char RAMs hold; the decoder control owns the write port.

## Interface
- STACK_AW, 12: stack address width; depth = 2^STACK_AW entries (4096 covers the longest legal string).
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  system reset; synchronous and active-low.
- code_in  in  13  code to unwind; 0–255 literal, 256–4095 dictionary index, ≥4096 illegal.
- code_valid  in  1  code_in valid.
- code_ready  out  1  block can accept a code.
- dict_en  out  1  dictionary read enable.
- dict_addr  out  12  dictionary read address.
- dict_prefix  in  13  prefix code read data; valid the cycle after dict_en.
- dict_char  in  8  append char read data; valid the cycle after dict_en.
- char_out  out  8  output character.
- char_valid  out  1  char_out valid.
- char_ready  in  1  downstream accepts char_out.
- char_last  out  1  char_out is the final character of the string.
- first_char  out  8  first (root) character of the most recently unwound string.
- busy  out  1  state ≠ IDLE.
- err  out  1  one-cycle pulse on illegal code or stack overflow.

## Operation
- States: IDLE, READ, WAIT, LIT, POP.
- IDLE: code_ready=1. Accept on code_valid & code_ready.
  - code_in < 256: push code_in[7:0], load first_char, go to POP.
  - 256 ≤ code_in ≤ 4095: load cur ← code_in, go to READ.
  - code_in ≥ 4096: pulse err, stay in IDLE.
- READ: dict_en=1, dict_addr=cur[11:0]; go to WAIT. dict_en is 0 in every other state; dict_addr holds its last value.
- WAIT: push dict_char; cur ← dict_prefix.
  - dict_prefix < 256: go to LIT.
  - 256 ≤ dict_prefix ≤ 4095: go to READ.
  - dict_prefix ≥ 4096: pulse err, clear stack, go to IDLE.
- LIT: push cur[7:0], first_char ← cur[7:0], go to POP.
- POP: char_valid=1, char_out=top of stack, char_last=(count==1).
  - On char_valid & char_ready: pop.
  - When the last entry pops, go to IDLE the next cycle.
  - char_out and char_last hold stable while stalled.
- Stack: sp counter, width STACK_AW+1.
  - A push with count == 2^STACK_AW pulses err, clears the stack and returns to IDLE; no character is emitted.
- Only one code is in flight at a time; no new code is accepted until POP completes.
- Reset: rst_n low for one edge forces state=IDLE, sp=0, first_char=0, err=0, dict_addr=0.
  - code_ready is gated low while rst_n is low.
  - Reset mid-walk or mid-POP discards the stack contents; nothing further is emitted.
- Reset values: code_ready 0 (1 the first cycle after release), dict_en 0, dict_addr 0, char_valid 0, char_out 0, char_last 0, first_char 0, busy 0, err 0.

## Timing
- Literal accepted at cycle T: char_valid at T+1 with char_last=1.
- Dictionary code whose string has length L ≥ 2, accepted at T:
  - L−1 READ/WAIT pairs occupy T+1 … T+2(L−1).
  - LIT at T+2(L−1)+1.
  - First char_valid at T+2L.
- Dictionary read latency is exactly 1 cycle. dict_prefix and dict_char are sampled only in WAIT.
- POP emits one character per cycle while char_ready=1. A string of length L drains in L cycles with no stall.
- code_ready reasserts the cycle after the final pop.
- Back-to-back gap: last character handshake at cycle N gives code_ready at N+1.
- err is a single-cycle pulse registered with the state change. code_ready is 1 the cycle after an abort.

## Test plan
- Literal: code_in=0x41 with char_ready=1 -> cycle T+1: char_out=0x41, char_last=1, first_char=0x41; code_ready=1 at T+2.
- Two-level string: entry 300={prefix 0x61, char 0x62}, entry 301={prefix 300, char 0x63}, code 301 -> dict_addr 301 then 300; output 'a','b','c', char_last only on 'c'; first_char=0x61; first char_valid at T+6.
- Backpressure: same as previous with char_ready toggling 1,0,0,1,1 -> each character emitted exactly once in order; char_out stable while stalled.
- Illegal code: code_in=0x1000 -> err pulse one cycle, no dict_en, no char_valid, code_ready stays 1. Dictionary prefix 0x1FFF returned mid-walk -> err pulse, return to IDLE, no output.
- Overflow: STACK_AW=3, chain of 9 dictionary levels -> err on the 9th push; stack cleared; no char_valid.
- Reset mid-POP: rst_n low for one cycle while 2 characters remain -> next cycle char_valid=0, busy=0, first_char=0. A subsequent literal 0x7A emits 0x7A only.
